oam_sprite_scanner: RTL

- Per-line OAM search engine that writes the 10-entry sprite store consumed by the sprite X matchers.
- At the start of each visible line it walks OAM entries 0..39 and tests each Y against LY and the object height.
- It loads the X position, OAM index and row offset of the first 10 hits into consecutive store slots using one-hot store strobes.
- It is the writer side of the matcher interface: the matchers latch on a strobe, and this block decides which slot gets which sprite and when.

---
 rtl/oam_sprite_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/oam_sprite_scanner.sv
// Per-line OAM search: scans 40 entries against LY and writes the first 10 hits into the sprite store.
// Optional scan_overflow output is enabled by defining OAM_SCAN_OVERFLOW_EN.
module oam_sprite_scanner #(
  parameter int NUM_ENTRIES = 40,
  parameter int MAX_SPRITES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_start,
  input  logic [7:0]             ly,
  input  logic                   obj_size,
  output logic [5:0]             oam_idx,
  input  logic [7:0]             oam_y,
  input  logic [7:0]             oam_x,
  output logic [MAX_SPRITES-1:0] store_en,
  output logic [7:0]             store_x,
  output logic [5:0]             store_idx,
  output logic [3:0]             store_line,
  output logic [3:0]             sprite_count,
  output logic                   scan_busy,
`ifdef OAM_SCAN_OVERFLOW_EN
  output logic                   scan_done,
  output logic                   scan_overflow
`else
  output logic                   scan_done
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [5:0]             LAST_IDX = 6'(NUM_ENTRIES - 1);
  localparam logic [3:0]             MAX_CNT  = 4'(MAX_SPRITES);
  localparam logic [MAX_SPRITES-1:0] SLOT0    = {{(MAX_SPRITES-1){1'b0}}, 1'b1};

  state_t     state_r;
  logic [7:0] ly_r;
  logic       size_r;
  logic       eval_vld_r;
  logic [5:0] eval_idx_r;

  logic [7:0] diff_s;
  logic       hit_s;
  logic [3:0] line_s;
  logic       store_go_s;

  // Hit test and row offset for the entry returned by memory this cycle.
  always_comb begin
    diff_s = ly_r + 8'd16 - oam_y;
    if (size_r) begin
      hit_s  = (diff_s < 8'd16);
      line_s = diff_s[3:0];
    end else begin
      hit_s  = (diff_s < 8'd8);
      line_s = {1'b0, diff_s[2:0]};
    end
    store_go_s = eval_vld_r && hit_s && (sprite_count < MAX_CNT);
  end

  // Scan sequencer, read-pipeline tracking and registered store outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      ly_r         <= 8'd0;
      size_r       <= 1'b0;
      eval_vld_r   <= 1'b0;
      eval_idx_r   <= 6'd0;
      oam_idx      <= 6'd0;
      store_en     <= '0;
      store_x      <= 8'd0;
      store_idx    <= 6'd0;
      store_line   <= 4'd0;
      sprite_count <= 4'd0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      store_en  <= '0;
      scan_done <= 1'b0;
      if (scan_start) begin
        // A restart discards whatever entry is still in the read pipeline.
        state_r      <= SCAN;
        ly_r         <= ly;
        size_r       <= obj_size;
        eval_vld_r   <= 1'b0;
        oam_idx      <= 6'd0;
        sprite_count <= 4'd0;
        scan_busy    <= 1'b1;
      end else begin
        eval_vld_r <= (state_r == SCAN);
        eval_idx_r <= oam_idx;
        if (store_go_s) begin
          store_en     <= SLOT0 << sprite_count;
          store_x      <= oam_x;
          store_idx    <= eval_idx_r;
          store_line   <= line_s;
          sprite_count <= sprite_count + 4'd1;
        end
        case (state_r)
          IDLE: state_r <= IDLE;
          SCAN: begin
            if (oam_idx == LAST_IDX) begin
              state_r <= DRAIN;
            end else begin
              oam_idx <= oam_idx + 6'd1;
            end
          end
          DRAIN: begin
            state_r   <= DONE;
            scan_busy <= 1'b0;
          end
          DONE: begin
            state_r   <= IDLE;
            scan_done <= 1'b1;
          end
          default: begin
            state_r   <= IDLE;
            scan_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OAM_SCAN_OVERFLOW_EN
  // Sticky flag: a hit arrived after every store slot was already taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_overflow <= 1'b0;
    end else if (scan_start) begin
      scan_overflow <= 1'b0;
    end else if (eval_vld_r && hit_s && (sprite_count == MAX_CNT)) begin
      scan_overflow <= 1'b1;
    end else begin
      scan_overflow <= scan_overflow;
    end
  end
`endif

endmodule
